dds_sweep_ctrl: RTL and testbench

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

---
 rtl/dds_sweep_ctrl_if.sv | 50 +++++
 rtl/dds_sweep_ctrl.sv | 149 ++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dds_sweep_ctrl_if.sv
// Purpose: bundles the sweep configuration handshake, abort and DDS output bus of dds_sweep_ctrl.
// Latency: none, wires only.
// Backpressure: cfg_valid/cfg_ready handshake; the outputs are never stalled.
//
// Signals:
//   cfg_valid/cfg_ready       configuration handshake (master -> slave / slave -> master)
//   cfg_k_start/step/stop     32-bit frequency words: start, increment, inclusive end
//   cfg_dwell                 cycles each word is held (0 is treated as 1)
//   cfg_phase                 11-bit phase offset for the whole sweep
//   cfg_mode                  0 = single sweep, 1 = continuous
//   abort                     terminates the sweep in progress
//   K, P                      registered frequency word / phase offset to the DDS
//   k_valid                   one-cycle pulse whenever K has just taken a new value
//   busy, done                sweep in progress / natural end of a single sweep
//
// Modports: master drives the configuration and abort; slave is the sweep controller.

interface dds_sweep_ctrl_if #(
  parameter int DWELL_W = 16
);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [31:0]        cfg_k_start;
  logic [31:0]        cfg_k_step;
  logic [31:0]        cfg_k_stop;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [10:0]        cfg_phase;
  logic               cfg_mode;
  logic               abort;

  logic [31:0]        K;
  logic [10:0]        P;
  logic               k_valid;
  logic               busy;
  logic               done;

  modport master (
    output cfg_valid, cfg_k_start, cfg_k_step, cfg_k_stop, cfg_dwell,
           cfg_phase, cfg_mode, abort,
    input  cfg_ready, K, P, k_valid, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_k_start, cfg_k_step, cfg_k_stop, cfg_dwell,
           cfg_phase, cfg_mode, abort,
    output cfg_ready, K, P, k_valid, busy, done
  );

endinterface

// File: rtl/dds_sweep_ctrl.sv
// Purpose: steps a DDS frequency word from start to stop in fixed increments, holding each word for a dwell time.
// Latency: first word appears two edges after the configuration handshake; each word is held max(dwell,1) cycles.
// Backpressure: cfg_ready is high only when idle (and abort low); configurations offered while sweeping are dropped.
//
// Ports:
//   clk     system clock, all state updates on its rising edge
//   rst_n   asynchronous active-low reset
//   bus     dds_sweep_ctrl_if.slave: configuration handshake, abort, K/P/k_valid/busy/done outputs

module dds_sweep_ctrl #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  dds_sweep_ctrl_if.slave    bus
);

  // FSM encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DWELL = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

  logic [1:0]         r_state;

  // Shadow copy of the configuration, stable for the whole sweep
  logic [31:0]        r_start;
  logic [31:0]        r_step;
  logic [31:0]        r_stop;
  logic [DWELL_W-1:0] r_dwell;
  logic [10:0]        r_phase;
  logic               r_mode;

  // Output registers and dwell counter
  logic [31:0]        r_k;
  logic [10:0]        r_p;
  logic               r_k_valid;
  logic [DWELL_W-1:0] r_cnt;

  logic               w_cfg_ready;
  logic               w_handshake;
  logic [DWELL_W-1:0] w_dwell_eff;
  logic [32:0]        w_next;
  logic               w_advance;
  logic               w_last_cycle;

  assign w_cfg_ready  = (r_state == S_IDLE) && !bus.abort;
  assign w_handshake  = bus.cfg_valid && w_cfg_ready;

  // A zero dwell still holds each word for one cycle.
  assign w_dwell_eff  = (r_dwell == '0) ? DWELL_ONE : r_dwell;

  // The next word is formed at 33 bits so that a carry out of the 32-bit
  // word ends the sweep instead of wrapping back to a small frequency.
  // A zero step would repeat the same word forever, so it also ends the sweep.
  assign w_next       = {1'b0, r_k} + {1'b0, r_step};
  assign w_advance    = (r_step != '0) && !w_next[32] && (w_next[31:0] <= r_stop);

  // The counter is loaded with the hold time and the word changes on the
  // edge where it reads 1, giving exactly dwell_eff cycles per word.
  assign w_last_cycle = (r_cnt == DWELL_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_start   <= '0;
      r_step    <= '0;
      r_stop    <= '0;
      r_dwell   <= '0;
      r_phase   <= '0;
      r_mode    <= 1'b0;
      r_k       <= '0;
      r_p       <= '0;
      r_k_valid <= 1'b0;
      r_cnt     <= '0;
    end else begin
      // k_valid is a pulse: only the branches that load K raise it again.
      r_k_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_handshake) begin
            r_start <= bus.cfg_k_start;
            r_step  <= bus.cfg_k_step;
            r_stop  <= bus.cfg_k_stop;
            r_dwell <= bus.cfg_dwell;
            r_phase <= bus.cfg_phase;
            r_mode  <= bus.cfg_mode;
            r_state <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (bus.abort) begin
            r_state <= S_IDLE;
          end else begin
            r_k       <= r_start;
            r_p       <= r_phase;
            r_k_valid <= 1'b1;
            r_cnt     <= w_dwell_eff;
            r_state   <= S_DWELL;
          end
        end

        S_DWELL: begin
          if (bus.abort) begin
            // K and P freeze at whatever the DDS is currently running.
            r_state <= S_IDLE;
          end else if (w_last_cycle) begin
            if (w_advance) begin
              r_k       <= w_next[31:0];
              r_k_valid <= 1'b1;
              r_cnt     <= w_dwell_eff;
            end else if (r_mode) begin
              // Continuous mode: wrap back to the start word.
              r_k       <= r_start;
              r_k_valid <= 1'b1;
              r_cnt     <= w_dwell_eff;
            end else begin
              r_state <= S_DONE;
            end
          end else begin
            r_cnt <= r_cnt - DWELL_ONE;
          end
        end

        S_DONE: begin
          // done is asserted for exactly this one cycle; abort leads to the
          // same place so it needs no separate branch.
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cfg_ready = w_cfg_ready;
  assign bus.K         = r_k;
  assign bus.P         = r_p;
  assign bus.k_valid   = r_k_valid;
  assign bus.busy      = (r_state == S_LOAD) || (r_state == S_DWELL);
  assign bus.done      = (r_state == S_DONE);

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
`timescale 1ns/1ps

module tb_dds_sweep_ctrl;

  localparam int DWELL_W = 16;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  dds_sweep_ctrl_if #(.DWELL_W(DWELL_W)) bus ();

  dds_sweep_ctrl #(.DWELL_W(DWELL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // One expected observation per clock cycle, sampled on the falling edge.
  typedef struct {
    logic [31:0] k;
    logic [10:0] p;
    logic        kv;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_k;
  logic [10:0] m_p;
  int          n_checks;
  int          n_fails;
  int          obs_kv;
  int          obs_busy;
  int          obs_done;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: list the words the sweep visits with plain 64-bit
  // arithmetic, then expand each into dwell_eff cycles of observations.
  // Sample 0 is the cycle right after the handshake edge.
  task automatic build_trace(input logic [31:0] start, input logic [31:0] step,
                             input logic [31:0] stop, input logic [DWELL_W-1:0] dwell,
                             input logic [10:0] phase, input logic mode,
                             input int max_len, input int abort_at);
    logic [31:0]     words[$];
    longint unsigned w;
    longint unsigned n;
    int              deff;
    exp_t            e;
    exp_q.delete();
    deff = (dwell == 0) ? 1 : int'(dwell);
    words.push_back(start);
    w = longint'(start);
    if (step != 0) begin
      while (1) begin
        n = w + longint'(step);
        if (n > longint'(stop)) break;
        words.push_back(n[31:0]);
        w = n;
      end
    end
    exp_q.push_back('{m_k, m_p, 1'b0, 1'b1, 1'b0});
    do begin
      foreach (words[j])
        for (int d = 0; d < deff; d++)
          exp_q.push_back('{words[j], phase, (d == 0), 1'b1, 1'b0});
    end while (mode && exp_q.size() < max_len);
    if (!mode) begin
      exp_q.push_back('{words[$], phase, 1'b0, 1'b0, 1'b1});
      exp_q.push_back('{words[$], phase, 1'b0, 1'b0, 1'b0});
    end
    // Abort on the edge producing sample abort_at: outputs freeze at the
    // previous cycle's K/P and everything goes idle.
    if (abort_at > 0 && abort_at <= exp_q.size()) begin
      e = exp_q[abort_at-1];
      e.kv = 1'b0;
      e.busy = 1'b0;
      e.done = 1'b0;
      while (exp_q.size() > abort_at) void'(exp_q.pop_back());
      exp_q.push_back(e);
      exp_q.push_back(e);
    end
  endtask

  task automatic run_sweep(input string name, input logic [31:0] start, input logic [31:0] step,
                           input logic [31:0] stop, input logic [DWELL_W-1:0] dwell,
                           input logic [10:0] phase, input logic mode,
                           input int max_len, input int abort_at);
    logic ab;
    logic exp_rdy;
    build_trace(start, step, stop, dwell, phase, mode, max_len, abort_at);
    obs_kv = 0;
    obs_busy = 0;
    obs_done = 0;
    @(negedge clk);
    check_eq({name, ":ready_before"}, 64'(bus.cfg_ready), 64'd1);
    bus.cfg_k_start = start;
    bus.cfg_k_step  = step;
    bus.cfg_k_stop  = stop;
    bus.cfg_dwell   = dwell;
    bus.cfg_phase   = phase;
    bus.cfg_mode    = mode;
    bus.cfg_valid   = 1'b1;
    bus.abort       = 1'b0;
    ab = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      exp_rdy = !exp_q[i].busy && !exp_q[i].done && !ab;
      check_eq({name, ":K"},       64'(bus.K),         64'(exp_q[i].k));
      check_eq({name, ":P"},       64'(bus.P),         64'(exp_q[i].p));
      check_eq({name, ":k_valid"}, 64'(bus.k_valid),   64'(exp_q[i].kv));
      check_eq({name, ":busy"},    64'(bus.busy),      64'(exp_q[i].busy));
      check_eq({name, ":done"},    64'(bus.done),      64'(exp_q[i].done));
      check_eq({name, ":ready"},   64'(bus.cfg_ready), 64'(exp_rdy));
      if (bus.k_valid === 1'b1) obs_kv++;
      if (bus.busy === 1'b1)    obs_busy++;
      if (bus.done === 1'b1)    obs_done++;
      ab = (i + 1 == abort_at);
      bus.abort = ab;
      // While the block is not idle, offer junk configurations that must be dropped.
      if (exp_q[i].busy || exp_q[i].done) begin
        bus.cfg_valid   = 1'($urandom_range(0, 1));
        bus.cfg_k_start = $urandom;
        bus.cfg_k_step  = $urandom;
        bus.cfg_k_stop  = $urandom;
        bus.cfg_dwell   = DWELL_W'($urandom);
        bus.cfg_phase   = 11'($urandom);
        bus.cfg_mode    = 1'($urandom);
      end else begin
        bus.cfg_valid = 1'b0;
      end
    end
    bus.abort = 1'b0;
    bus.cfg_valid = 1'b0;
    m_k = exp_q[$].k;
    m_p = exp_q[$].p;
  endtask

  initial begin
    logic [31:0]     r_start;
    logic [31:0]     r_step;
    logic [31:0]     r_stop;
    longint unsigned s64;
    logic            r_mode;
    int              r_abort;

    n_checks = 0;
    n_fails  = 0;
    m_k = '0;
    m_p = '0;
    rst_n = 1'b0;
    bus.cfg_valid   = 1'b0;
    bus.abort       = 1'b0;
    bus.cfg_k_start = '0;
    bus.cfg_k_step  = '0;
    bus.cfg_k_stop  = '0;
    bus.cfg_dwell   = '0;
    bus.cfg_phase   = '0;
    bus.cfg_mode    = 1'b0;

    #12;
    check_eq("rst:K",       64'(bus.K),         64'd0);
    check_eq("rst:P",       64'(bus.P),         64'd0);
    check_eq("rst:k_valid", 64'(bus.k_valid),   64'd0);
    check_eq("rst:busy",    64'(bus.busy),      64'd0);
    check_eq("rst:done",    64'(bus.done),      64'd0);
    check_eq("rst:ready",   64'(bus.cfg_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic single sweep: 100,150,200,250 held 3 cycles each.
    run_sweep("basic", 32'd100, 32'd50, 32'd250, 16'd3, 11'h155, 1'b0, 1000, 0);
    check_eq("basic:kv_pulses",  64'(obs_kv),   64'd4);
    check_eq("basic:busy_cyc",   64'(obs_busy), 64'd13);
    check_eq("basic:done_cnt",   64'(obs_done), 64'd1);

    // Continuous sweep with dwell 1: k_valid every cycle, no done.
    run_sweep("cont", 32'd0, 32'd10, 32'd20, 16'd1, 11'h007, 1'b1, 14, 14);
    check_eq("cont:kv_pulses",   64'(obs_kv),   64'd13);
    check_eq("cont:done_cnt",    64'(obs_done), 64'd0);

    // First step would carry past 2^32: only the start word is emitted.
    run_sweep("carry", 32'hFFFF_FFF0, 32'h20, 32'hFFFF_FFFF, 16'd2, 11'h000, 1'b0, 1000, 0);
    check_eq("carry:kv_pulses",  64'(obs_kv),   64'd1);
    check_eq("carry:done_cnt",   64'(obs_done), 64'd1);

    // Abort on the second cycle of K=150.
    run_sweep("abort", 32'd100, 32'd50, 32'd250, 16'd3, 11'h2AA, 1'b0, 1000, 6);
    check_eq("abort:done_cnt",   64'(obs_done), 64'd0);

    // Zero dwell behaves as one cycle per word.
    run_sweep("dwell0", 32'd1000, 32'd7, 32'd1030, 16'd0, 11'h011, 1'b0, 1000, 0);
    check_eq("dwell0:kv_pulses", 64'(obs_kv),   64'd5);
    check_eq("dwell0:busy_cyc",  64'(obs_busy), 64'd6);

    // Degenerate configurations: start above stop, zero step.
    run_sweep("rev",    32'd500, 32'd1, 32'd100, 16'd2, 11'h123, 1'b0, 1000, 0);
    check_eq("rev:kv_pulses",    64'(obs_kv),   64'd1);
    run_sweep("step0",  32'd5, 32'd0, 32'd1000, 16'd2, 11'h321, 1'b0, 1000, 0);
    check_eq("step0:kv_pulses",  64'(obs_kv),   64'd1);
    run_sweep("step0c", 32'd5, 32'd0, 32'd1000, 16'd2, 11'h321, 1'b1, 9, 9);
    check_eq("step0c:kv_pulses", 64'(obs_kv),   64'd4);

    // Reset in the middle of a sweep while K=200, P=0x3FF.
    @(negedge clk);
    bus.cfg_k_start = 32'd0;
    bus.cfg_k_step  = 32'd100;
    bus.cfg_k_stop  = 32'd1000;
    bus.cfg_dwell   = 16'd2;
    bus.cfg_phase   = 11'h3FF;
    bus.cfg_mode    = 1'b0;
    bus.cfg_valid   = 1'b1;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("midrst:K_before", 64'(bus.K), 64'd200);
    check_eq("midrst:P_before", 64'(bus.P), 64'h3FF);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst:K",       64'(bus.K),         64'd0);
    check_eq("midrst:P",       64'(bus.P),         64'd0);
    check_eq("midrst:busy",    64'(bus.busy),      64'd0);
    check_eq("midrst:k_valid", 64'(bus.k_valid),   64'd0);
    check_eq("midrst:done",    64'(bus.done),      64'd0);
    check_eq("midrst:ready",   64'(bus.cfg_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    m_k = '0;
    m_p = '0;
    run_sweep("postrst", 32'd7, 32'd3, 32'd13, 16'd1, 11'h02A, 1'b0, 1000, 0);
    check_eq("postrst:kv_pulses", 64'(obs_kv), 64'd3);

    // Randomized sweeps.
    repeat (40) begin
      if ($urandom_range(0, 3) == 0) r_start = 32'hFFFF_FFFF - 32'($urandom_range(0, 600));
      else                           r_start = $urandom;
      r_step = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(50, 400));
      case ($urandom_range(0, 3))
        0: r_stop = r_start - 32'($urandom_range(1, 1000));
        1: begin
          s64 = longint'(r_start) + longint'($urandom_range(0, 1500));
          r_stop = (s64 > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s64[31:0];
        end
        default: begin
          s64 = longint'(r_start) + longint'($urandom_range(0, 800));
          r_stop = (s64 > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s64[31:0];
        end
      endcase
      r_mode = 1'($urandom_range(0, 1));
      if (r_mode || $urandom_range(0, 3) == 0) r_abort = $urandom_range(1, 60);
      else                                     r_abort = 0;
      run_sweep("rand", r_start, r_step, r_stop, DWELL_W'($urandom_range(0, 4)),
                11'($urandom), r_mode, 60, r_abort);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
